// File: rtl/status_pkg.sv
// Shared status-word definitions for the status unit and branch-condition logic.
package status_pkg;
  localparam int FLAG_W = 5;
  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_P = 2;
  localparam int FLAG_N = 3;
  localparam int FLAG_V = 4;

  // Field order matches the bit indices above: {V, N, P, Z, C}.
  typedef struct packed {
    logic v;
    logic n;
    logic p;
    logic z;
    logic c;
  } status_t;

  // Per-bit select: take nxt where mask is set, keep cur elsewhere.
  function automatic status_t merge_masked(status_t cur, status_t nxt,
                                           logic [FLAG_W-1:0] mask);
    return status_t'((cur & ~mask) | (nxt & mask));
  endfunction
endpackage

// File: rtl/status_flag_unit_if.sv
// Bus between the ALU/control unit (master) and the status unit (slave).
interface status_flag_unit_if
  import status_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int STACK_DEPTH = 4
);
  localparam int CNT_W = $clog2(STACK_DEPTH + 1);

  logic [DATA_W-1:0] alu_result;
  logic              alu_carry;
  logic              alu_ovf;
  logic              flag_we;
  logic [FLAG_W-1:0] flag_mask;
  logic              ld_en;
  logic [FLAG_W-1:0] ld_data;
  logic              push;
  logic              pop;
  logic              err_clr;
  logic [FLAG_W-1:0] status;
  logic              stack_empty;
  logic              stack_full;
  logic [CNT_W-1:0]  stack_cnt;
  logic              stack_err;

  modport master (
    output alu_result, alu_carry, alu_ovf, flag_we, flag_mask,
           ld_en, ld_data, push, pop, err_clr,
    input  status, stack_empty, stack_full, stack_cnt, stack_err
  );

  modport slave (
    input  alu_result, alu_carry, alu_ovf, flag_we, flag_mask,
           ld_en, ld_data, push, pop, err_clr,
    output status, stack_empty, stack_full, stack_cnt, stack_err
  );
endinterface

// File: rtl/status_flag_unit_stack.sv
// LIFO of saved status words with count, full/empty and sticky error.
module status_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 5,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          err_clr,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          pop_ok,
  output logic [CW-1:0] cnt,
  output logic          full,
  output logic          empty,
  output logic          err
);
  logic [DEPTH-1:0][W-1:0] mem;
  logic                    push_ok;
  logic                    err_set;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  // Simultaneous push+pop is a collision: neither operation is legal.
  assign push_ok = push && !pop && !full;
  assign pop_ok  = pop && !push && !empty;
  assign err_set = (push && pop) || (push && full) || (pop && empty);

  // Top-of-stack read; a compare loop avoids out-of-range indexing when cnt=0.
  always_comb begin
    dout = '0;
    for (int i = 0; i < DEPTH; i++)
      if (cnt == CW'(i + 1)) dout = mem[i];
  end

  // Storage write; contents after reset are don't-care, so no reset here.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++)
      if (push_ok && cnt == CW'(i)) mem[i] <= din;
  end

  // Entry count and sticky error; a new error beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      if (push_ok)     cnt <= cnt + 1'b1;
      else if (pop_ok) cnt <= cnt - 1'b1;
      if (err_set)      err <= 1'b1;
      else if (err_clr) err <= 1'b0;
    end
  end
endmodule

// File: rtl/status_flag_unit.sv
// Registered N/P/Z/C/V status unit with masked update, direct load and save stack.
module status_flag_unit
  import status_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int STACK_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  status_flag_unit_if.slave bus
);
  status_t           status_q;
  status_t           comp;
  logic [FLAG_W-1:0] comp_v;
  logic [FLAG_W-1:0] stack_top;
  logic              pop_ok;

  // Flags derived from the current ALU outputs; exactly one of N/P/Z is set.
  always_comb begin
    comp_v         = '0;
    comp_v[FLAG_Z] = (bus.alu_result == '0);
    comp_v[FLAG_N] = bus.alu_result[DATA_W-1];
    comp_v[FLAG_P] = !comp_v[FLAG_N] && !comp_v[FLAG_Z];
    comp_v[FLAG_C] = bus.alu_carry;
    comp_v[FLAG_V] = bus.alu_ovf;
    comp           = status_t'(comp_v);
  end

  status_stack #(.DEPTH(STACK_DEPTH), .W(FLAG_W)) u_stack (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (bus.push),
    .pop     (bus.pop),
    .err_clr (bus.err_clr),
    .din     (status_q),
    .dout    (stack_top),
    .pop_ok  (pop_ok),
    .cnt     (bus.stack_cnt),
    .full    (bus.stack_full),
    .empty   (bus.stack_empty),
    .err     (bus.stack_err)
  );

  // Status register: legal pop > direct load > masked ALU update > hold.
  always_ff @(posedge clk) begin
    if (!rst_n)           status_q <= '0;
    else if (pop_ok)      status_q <= status_t'(stack_top);
    else if (bus.ld_en)   status_q <= status_t'(bus.ld_data);
    else if (bus.flag_we) status_q <= merge_masked(status_q, comp, bus.flag_mask);
  end

  assign bus.status = status_q;
endmodule

// File: tb/tb_status_flag_unit.sv
// Self-checking bench: directed scenarios plus randomized traffic against a queue model.
module tb_status_flag_unit;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic rst_n;
  int   chk_cnt  = 0;
  int   pass_cnt = 0;

  // Reference state: status word, saved words as a queue (back = top), error flag.
  logic [4:0] m_st;
  logic [4:0] m_q[$];
  logic       m_err;

  status_flag_unit_if #(.DATA_W(DATA_W), .STACK_DEPTH(DEPTH)) bus ();

  status_flag_unit #(.DATA_W(DATA_W), .STACK_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic idle();
    bus.alu_result = '0; bus.alu_carry = 1'b0; bus.alu_ovf = 1'b0;
    bus.flag_we = 1'b0; bus.flag_mask = '0; bus.ld_en = 1'b0; bus.ld_data = '0;
    bus.push = 1'b0; bus.pop = 1'b0; bus.err_clr = 1'b0;
  endtask

  // Apply the architectural rules to the inputs about to be sampled.
  task automatic model_step();
    logic [4:0] comp;
    logic [4:0] old;
    bit n, z, full, empty, e;
    if (!rst_n) begin
      m_st = '0; m_q.delete(); m_err = 1'b0;
      return;
    end
    full  = (m_q.size() == DEPTH);
    empty = (m_q.size() == 0);
    z = (bus.alu_result == 0);
    n = bus.alu_result[DATA_W-1];
    comp = {bus.alu_ovf, n, !n && !z, z, bus.alu_carry};
    old = m_st;
    e = (bus.push && bus.pop) || (bus.push && !bus.pop && full) || (bus.pop && !bus.push && empty);
    if (bus.pop && !bus.push && !empty) m_st = m_q.pop_back();
    else if (bus.ld_en) m_st = bus.ld_data;
    else if (bus.flag_we)
      for (int i = 0; i < 5; i++) if (bus.flag_mask[i]) m_st[i] = comp[i];
    if (bus.push && !bus.pop && !full) m_q.push_back(old);
    if (e) m_err = 1'b1;
    else if (bus.err_clr) m_err = 1'b0;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cycle();
    chk_cnt++; if (bus.status !== 5'h00) $display("FAIL reset_status got %h want 00", bus.status); else pass_cnt++;
    chk_cnt++; if (bus.stack_cnt !== 3'd0) $display("FAIL reset_cnt got %0d want 0", bus.stack_cnt); else pass_cnt++;
    chk_cnt++; if ({bus.stack_empty, bus.stack_full, bus.stack_err} !== 3'b100)
      $display("FAIL reset_flags got e/f/err=%b want 100", {bus.stack_empty, bus.stack_full, bus.stack_err}); else pass_cnt++;
    rst_n = 1'b1;
  endtask

  task automatic test_flags();
    bus.flag_we = 1'b1; bus.flag_mask = 5'b11111; bus.alu_result = 16'h0000; bus.alu_carry = 1'b1;
    cycle();
    chk_cnt++; if (bus.status !== 5'b00011) $display("FAIL flags_zero got %b want 00011", bus.status); else pass_cnt++;
    bus.flag_we = 1'b1; bus.flag_mask = 5'b01110; bus.alu_result = 16'h8000; bus.alu_ovf = 1'b1;
    cycle();
    chk_cnt++; if (bus.status !== 5'b01001) $display("FAIL flags_mask got %b want 01001", bus.status); else pass_cnt++;
  endtask

  task automatic test_stack_fill();
    for (int k = 0; k < 4; k++) begin
      bus.ld_en = 1'b1; bus.ld_data = 5'(1 << k);
      cycle();
      bus.push = 1'b1;
      cycle();
    end
    chk_cnt++; if ({bus.stack_full, bus.stack_cnt} !== {1'b1, 3'd4})
      $display("FAIL fill_full got full=%b cnt=%0d want 1/4", bus.stack_full, bus.stack_cnt); else pass_cnt++;
    bus.push = 1'b1;
    cycle();
    chk_cnt++; if ({bus.stack_err, bus.stack_cnt} !== {1'b1, 3'd4})
      $display("FAIL push_full got err=%b cnt=%0d want 1/4", bus.stack_err, bus.stack_cnt); else pass_cnt++;
    for (int k = 3; k >= 0; k--) begin
      logic [4:0] exp_st;
      exp_st = 5'(1 << k);
      bus.pop = 1'b1;
      cycle();
      chk_cnt++; if (bus.status !== exp_st) $display("FAIL drain_%0d got %h want %h", k, bus.status, exp_st); else pass_cnt++;
    end
    chk_cnt++; if ({bus.stack_empty, bus.stack_cnt} !== {1'b1, 3'd0})
      $display("FAIL drain_empty got empty=%b cnt=%0d want 1/0", bus.stack_empty, bus.stack_cnt); else pass_cnt++;
    bus.err_clr = 1'b1;
    cycle();
  endtask

  task automatic test_pop_empty();
    bus.pop = 1'b1; bus.ld_en = 1'b1; bus.ld_data = 5'h15;
    cycle();
    chk_cnt++; if ({bus.status, bus.stack_err} !== {5'h15, 1'b1})
      $display("FAIL pop_empty got st=%h err=%b want 15/1", bus.status, bus.stack_err); else pass_cnt++;
    bus.err_clr = 1'b1;
    cycle();
    chk_cnt++; if (bus.stack_err !== 1'b0) $display("FAIL err_clr got %b want 0", bus.stack_err); else pass_cnt++;
  endtask

  task automatic test_collision();
    bus.push = 1'b1; bus.flag_we = 1'b1; bus.flag_mask = 5'b11111; bus.alu_result = 16'h0005;
    cycle();
    chk_cnt++; if ({bus.status, bus.stack_cnt} !== {5'b00100, 3'd1})
      $display("FAIL push_we got st=%b cnt=%0d want 00100/1", bus.status, bus.stack_cnt); else pass_cnt++;
    bus.push = 1'b1; bus.pop = 1'b1;
    cycle();
    chk_cnt++; if ({bus.status, bus.stack_cnt, bus.stack_err} !== {5'b00100, 3'd1, 1'b1})
      $display("FAIL push_pop got st=%b cnt=%0d err=%b want 00100/1/1", bus.status, bus.stack_cnt, bus.stack_err); else pass_cnt++;
    bus.pop = 1'b1;
    cycle();
    chk_cnt++; if ({bus.status, bus.stack_cnt} !== {5'h15, 3'd0})
      $display("FAIL pushed_old got st=%h cnt=%0d want 15/0", bus.status, bus.stack_cnt); else pass_cnt++;
    bus.err_clr = 1'b1;
    cycle();
  endtask

  task automatic test_reset_mid();
    bus.ld_en = 1'b1; bus.ld_data = 5'h1F;
    cycle();
    for (int k = 0; k < 3; k++) begin
      bus.push = 1'b1;
      cycle();
    end
    bus.push = 1'b1; bus.pop = 1'b1;
    cycle();
    chk_cnt++; if ({bus.status, bus.stack_cnt, bus.stack_err} !== {5'h1F, 3'd3, 1'b1})
      $display("FAIL pre_reset got st=%h cnt=%0d err=%b want 1f/3/1", bus.status, bus.stack_cnt, bus.stack_err); else pass_cnt++;
    rst_n = 1'b0; bus.ld_en = 1'b1; bus.ld_data = 5'h0A;
    cycle();
    rst_n = 1'b1;
    chk_cnt++; if ({bus.status, bus.stack_cnt, bus.stack_empty, bus.stack_err} !== {5'h00, 3'd0, 1'b1, 1'b0})
      $display("FAIL mid_reset got st=%h cnt=%0d empty=%b err=%b want 00/0/1/0",
               bus.status, bus.stack_cnt, bus.stack_empty, bus.stack_err); else pass_cnt++;
    bus.pop = 1'b1;
    cycle();
    chk_cnt++; if ({bus.status, bus.stack_err} !== {5'h00, 1'b1})
      $display("FAIL discarded got st=%h err=%b want 00/1", bus.status, bus.stack_err); else pass_cnt++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      logic [CNT_W-1:0] exp_cnt;
      rst_n          = ($urandom_range(0, 59) != 0);
      bus.alu_result = ($urandom_range(0, 5) == 0) ? '0 : DATA_W'($urandom);
      bus.alu_carry  = 1'($urandom);
      bus.alu_ovf    = 1'($urandom);
      bus.flag_we    = ($urandom_range(0, 1) == 0);
      bus.flag_mask  = 5'($urandom);
      bus.ld_en      = ($urandom_range(0, 5) == 0);
      bus.ld_data    = 5'($urandom);
      bus.push       = ($urandom_range(0, 2) == 0);
      bus.pop        = ($urandom_range(0, 2) == 0);
      bus.err_clr    = ($urandom_range(0, 7) == 0);
      cycle();
      exp_cnt = CNT_W'(m_q.size());
      chk_cnt++;
      if ({bus.status, bus.stack_cnt, bus.stack_empty, bus.stack_full, bus.stack_err} !==
          {m_st, exp_cnt, m_q.size() == 0, m_q.size() == DEPTH, m_err})
        $display("FAIL random_%0d got st=%h cnt=%0d e=%b f=%b err=%b want st=%h cnt=%0d err=%b",
                 c, bus.status, bus.stack_cnt, bus.stack_empty, bus.stack_full, bus.stack_err,
                 m_st, exp_cnt, m_err);
      else pass_cnt++;
    end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    idle();
    test_reset();
    test_flags();
    test_stack_fill();
    test_pop_empty();
    test_collision();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
